// File: rtl/calc_pkg.sv
// calc_pkg: shared command, response and FSM state encodings for the calc port responder
package calc_pkg;
  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;
  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_OK   = 2'b01,
    RESP_ERR  = 2'b10
  } resp_e;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GET_B,
    ST_EXEC,
    ST_RESP
  } state_e;
endpackage

// File: rtl/calc_alu.sv
// calc_alu: combinational unsigned add/sub/shift with overflow, underflow and invalid-command detection
module calc_alu
  import calc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        cmd_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  output logic [DATA_W-1:0] res_o,
  output logic [1:0]        resp_o
);
  localparam int SW = $clog2(DATA_W);
  logic [DATA_W:0] sum;
  assign sum = {1'b0, opa_i} + {1'b0, opb_i};
  always_comb begin
    res_o  = '0;
    resp_o = RESP_ERR;
    case (cmd_i)
      CMD_ADD: begin
        resp_o = sum[DATA_W] ? RESP_ERR : RESP_OK;
        res_o  = sum[DATA_W] ? '0 : sum[DATA_W-1:0];
      end
      CMD_SUB: begin
        resp_o = (opb_i > opa_i) ? RESP_ERR : RESP_OK;
        res_o  = (opb_i > opa_i) ? '0 : opa_i - opb_i;
      end
      CMD_SHL: begin
        resp_o = RESP_OK;
        res_o  = opa_i << opb_i[SW-1:0];
      end
      CMD_SHR: begin
        resp_o = RESP_OK;
        res_o  = opa_i >> opb_i[SW-1:0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/calc_port_responder.sv
// calc_port_responder: two-cycle request capture, fixed-latency execute, one-cycle registered response.
// Define CALC_DROP_CNT_EN to add the saturating drop_cnt output counting commands ignored while busy.
module calc_port_responder
  import calc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 3
) (
  input  logic              SysClk,
  input  logic              Rst,
  input  logic [3:0]        req_cmd_in,
  input  logic [DATA_W-1:0] req_data_in,
  output logic [1:0]        out_resp,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
`ifdef CALC_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  state_e            state_q;
  logic [3:0]        cmd_q;
  logic [DATA_W-1:0] opa_q, opb_q, alu_res;
  logic [CW-1:0]     cnt_q;
  logic [1:0]        alu_resp;
  calc_alu #(.DATA_W(DATA_W)) u_alu (
    .cmd_i (cmd_q),
    .opa_i (opa_q),
    .opb_i (opb_q),
    .res_o (alu_res),
    .resp_o(alu_resp)
  );
  always_ff @(posedge SysClk or posedge Rst) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      out_resp <= RESP_NONE;
      out_data <= '0;
      busy     <= 1'b0;
    end else begin
      out_resp <= RESP_NONE;
      out_data <= '0;
      case (state_q)
        ST_IDLE: if (req_cmd_in != '0) begin
          cmd_q   <= req_cmd_in;
          opa_q   <= req_data_in;
          busy    <= 1'b1;
          state_q <= ST_GET_B;
        end
        ST_GET_B: begin
          opb_q   <= req_data_in;
          cnt_q   <= CW'(LATENCY - 1);
          state_q <= ST_EXEC;
        end
        ST_EXEC: if (cnt_q == '0) begin
          out_resp <= alu_resp;
          out_data <= alu_res;
          state_q  <= ST_RESP;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end
`ifdef CALC_DROP_CNT_EN
  logic [15:0] drop_d;
  assign drop_d = (busy && req_cmd_in != '0 && drop_cnt != 16'hFFFF) ? drop_cnt + 16'd1 : drop_cnt;
  always_ff @(posedge SysClk or posedge Rst) begin
    if (Rst) drop_cnt <= '0;
    else drop_cnt <= drop_d;
  end
`endif
endmodule
